// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 decryption core.
package arc4_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    KSA,
    LEN,
    PRGA,
    DONE
  } state_t;

  localparam int    SBOX_SIZE = 256;
  localparam byte_t PRINT_LO  = 8'h20;
  localparam byte_t PRINT_HI  = 8'h7E;

endpackage

// File: rtl/arc4_key_sel.sv
// Combinational key-byte picker: returns key byte (idx mod KEY_BYTES), byte 0 in the top bits.
module arc4_key_sel
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = 3
) (
  input  logic [8*KEY_BYTES-1:0] key,
  input  byte_t                  idx,
  output byte_t                  key_byte
);

  int unsigned sel;

  always_comb begin
    sel      = 32'(idx) % 32'(KEY_BYTES);
    key_byte = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (sel == 32'(k)) key_byte = key[8*(KEY_BYTES-1-k) +: 8];
    end
  end

endmodule

// File: rtl/arc4_core.sv
// ARC4 decryption core driving external S, CT and PT RAMs (1-cycle read latency).
// Optional plaintext printability flag enabled by defining ARC4_VALID_CHECK_EN.
module arc4_core
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int MAX_LEN   = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren,
  input  logic [7:0]             s_rddata,
  output logic [7:0]             ct_addr,
  input  logic [7:0]             ct_rddata,
  output logic [7:0]             pt_addr,
  output logic [7:0]             pt_wrdata,
  output logic                   pt_wren,
  output logic                   bad
);

  localparam byte_t LEN_CAP = 8'(MAX_LEN);

  state_t                 state, state_n;
  logic [2:0]             step, step_n;
  byte_t                  i, i_n, j, j_n, k, k_n, len, len_n;
  byte_t                  si, si_n, sj, sj_n;
  logic [8*KEY_BYTES-1:0] key_r, key_n;
  byte_t                  key_byte, len_eff;

  arc4_key_sel #(.KEY_BYTES(KEY_BYTES)) u_key_sel (
    .key      (key_r),
    .idx      (i),
    .key_byte (key_byte)
  );

  assign rdy     = (state == IDLE);
  assign len_eff = (ct_rddata > LEN_CAP) ? LEN_CAP : ct_rddata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= '0;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      len   <= '0;
      si    <= '0;
      sj    <= '0;
      key_r <= '0;
    end else begin
      state <= state_n;
      step  <= step_n;
      i     <= i_n;
      j     <= j_n;
      k     <= k_n;
      len   <= len_n;
      si    <= si_n;
      sj    <= sj_n;
      key_r <= key_n;
    end
  end

  // RAM ports are driven combinationally from the current step so each read
  // returns its data in the very next step; swaps write s[i] then s[j] from
  // values captured before either write.
  always_comb begin
    state_n   = state;
    step_n    = step;
    i_n       = i;
    j_n       = j;
    k_n       = k;
    len_n     = len;
    si_n      = si;
    sj_n      = sj;
    key_n     = key_r;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_n = INIT;
          key_n   = key;
          step_n  = '0;
          i_n     = '0;
          j_n     = '0;
        end
      end
      INIT: begin
        s_addr   = i;
        s_wrdata = i;
        s_wren   = 1'b1;
        i_n      = i + 8'd1;
        if (i == 8'(SBOX_SIZE - 1)) state_n = KSA;
      end
      KSA: begin
        case (step)
          3'd0: begin
            s_addr = i;
            step_n = 3'd1;
          end
          3'd1: begin
            j_n    = j + s_rddata + key_byte;
            s_addr = j_n;
            si_n   = s_rddata;
            step_n = 3'd2;
          end
          3'd2: begin
            s_addr   = i;
            s_wrdata = s_rddata;
            s_wren   = 1'b1;
            step_n   = 3'd3;
          end
          default: begin
            s_addr   = j;
            s_wrdata = si;
            s_wren   = 1'b1;
            i_n      = i + 8'd1;
            step_n   = 3'd0;
            if (i == 8'(SBOX_SIZE - 1)) state_n = LEN;
          end
        endcase
      end
      LEN: begin
        if (step == 3'd0) begin
          step_n = 3'd1;
        end else begin
          pt_wrdata = len_eff;
          pt_wren   = 1'b1;
          len_n     = len_eff;
          i_n       = '0;
          j_n       = '0;
          k_n       = 8'd1;
          step_n    = 3'd0;
          state_n   = (len_eff == 8'd0) ? DONE : PRGA;
        end
      end
      PRGA: begin
        ct_addr = k;
        case (step)
          3'd0: begin
            i_n    = i + 8'd1;
            s_addr = i_n;
            step_n = 3'd1;
          end
          3'd1: begin
            j_n    = j + s_rddata;
            s_addr = j_n;
            si_n   = s_rddata;
            step_n = 3'd2;
          end
          3'd2: begin
            s_addr   = i;
            s_wrdata = s_rddata;
            s_wren   = 1'b1;
            sj_n     = s_rddata;
            step_n   = 3'd3;
          end
          3'd3: begin
            s_addr   = j;
            s_wrdata = si;
            s_wren   = 1'b1;
            step_n   = 3'd4;
          end
          3'd4: begin
            s_addr = si + sj;
            step_n = 3'd5;
          end
          default: begin
            pt_addr   = k;
            pt_wrdata = s_rddata ^ ct_rddata;
            pt_wren   = 1'b1;
            step_n    = 3'd0;
            if (k == len) state_n = DONE;
            else          k_n     = k + 8'd1;
          end
        endcase
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

`ifdef ARC4_VALID_CHECK_EN
  logic bad_r;

  // Sticky until the next accepted start; only message bytes are judged, not the length byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         bad_r <= 1'b0;
    else if (state == IDLE && en)       bad_r <= 1'b0;
    else if (state == PRGA && pt_wren &&
             (pt_wrdata < PRINT_LO || pt_wrdata > PRINT_HI))
                                        bad_r <= 1'b1;
  end

  assign bad = bad_r;
`else
  assign bad = 1'b0;
`endif

endmodule

// File: tb/tb_arc4_core.sv
// Scoreboard bench for arc4_core: two instances (3-byte key / default length, 4-byte key / MAX_LEN=16).
module tb_arc4_core;

  localparam int MAXL1 = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en [2];
  logic        rdy [2];
  logic [31:0] key_in [2];
  logic [7:0]  s_addr [2], s_wrdata [2], s_rddata [2];
  logic [7:0]  ct_addr [2], ct_rddata [2];
  logic [7:0]  pt_addr [2], pt_wrdata [2];
  logic        s_wren [2], pt_wren [2], bad [2];

  logic [7:0]  s_mem [2][256];
  logic [7:0]  ct_mem [2][256];
  logic [7:0]  pt_mem [2][256];

  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arc4_core #(.KEY_BYTES(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .rdy(rdy[0]), .key(key_in[0][23:0]),
    .s_addr(s_addr[0]), .s_wrdata(s_wrdata[0]), .s_wren(s_wren[0]), .s_rddata(s_rddata[0]),
    .ct_addr(ct_addr[0]), .ct_rddata(ct_rddata[0]),
    .pt_addr(pt_addr[0]), .pt_wrdata(pt_wrdata[0]), .pt_wren(pt_wren[0]), .bad(bad[0])
  );

  arc4_core #(.KEY_BYTES(4), .MAX_LEN(MAXL1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .rdy(rdy[1]), .key(key_in[1]),
    .s_addr(s_addr[1]), .s_wrdata(s_wrdata[1]), .s_wren(s_wren[1]), .s_rddata(s_rddata[1]),
    .ct_addr(ct_addr[1]), .ct_rddata(ct_rddata[1]),
    .pt_addr(pt_addr[1]), .pt_wrdata(pt_wrdata[1]), .pt_wren(pt_wren[1]), .bad(bad[1])
  );

  // Synchronous-read RAM models
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      s_rddata[g]  <= s_mem[g][s_addr[g]];
      ct_rddata[g] <= ct_mem[g][ct_addr[g]];
      if (s_wren[g])  s_mem[g][s_addr[g]]   <= s_wrdata[g];
      if (pt_wren[g]) pt_mem[g][pt_addr[g]] <= pt_wrdata[g];
    end
  end

  // Monitor: every plaintext write is matched against the head of its queue
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (pt_wren[g] === 1'b1) begin
        logic [15:0] e;
        int          sz;
        sz = (g == 0) ? exp_q0.size() : exp_q1.size();
        checks++;
        if (sz == 0) begin
          errors++;
          $display("[TB] FAIL pt_write_unexpected inst=%0d actual addr=%02h data=%02h required no write",
                   g, pt_addr[g], pt_wrdata[g]);
        end else begin
          e = (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          if ({pt_addr[g], pt_wrdata[g]} !== e) begin
            errors++;
            $display("[TB] FAIL pt_write inst=%0d actual addr=%02h data=%02h required addr=%02h data=%02h",
                     g, pt_addr[g], pt_wrdata[g], e[15:8], e[7:0]);
          end
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void push_exp(input int g, input int addr, input int data);
    if (g == 0) exp_q0.push_back({8'(addr), 8'(data)});
    else        exp_q1.push_back({8'(addr), 8'(data)});
  endfunction

  function automatic bit sbox_identity(input int g);
    for (int x = 0; x < 256; x++) if (s_mem[g][x] !== 8'(x)) return 1'b0;
    return 1'b1;
  endfunction

  // Reference RC4 decryption straight from the algorithm description
  function automatic void ref_push(input int g, input logic [31:0] kv, input int kb, input int maxl,
                                   output bit exp_bad, output int le);
    int s [256];
    int i, j, t, kbyte, ks, p, L;
    bit nonprint;
    for (int x = 0; x < 256; x++) s[x] = x;
    j = 0;
    for (int x = 0; x < 256; x++) begin
      kbyte = int'((kv >> (8 * (kb - 1 - (x % kb)))) & 32'hFF);
      j = (j + s[x] + kbyte) % 256;
      t = s[x]; s[x] = s[j]; s[j] = t;
    end
    L  = int'(ct_mem[g][0]);
    le = (L > maxl) ? maxl : L;
    push_exp(g, 0, le);
    i = 0; j = 0; nonprint = 1'b0;
    for (int n = 1; n <= le; n++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      ks = s[(s[i] + s[j]) % 256];
      p  = ks ^ int'(ct_mem[g][n]);
      push_exp(g, n, p);
      if (p < 32 || p > 126) nonprint = 1'b1;
    end
`ifdef ARC4_VALID_CHECK_EN
    exp_bad = nonprint;
`else
    exp_bad = 1'b0;
`endif
  endfunction

  task automatic apply_stimulus(input int g, input logic [31:0] kv);
    int t = 0;
    while (rdy[g] !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (rdy[g] !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL rdy_before_start inst=%0d actual=%b required=1", g, rdy[g]);
    end
    @(negedge clk);
    key_in[g] = kv;
    en[g]     = 1'b1;
    @(posedge clk);
    #1 en[g]  = 1'b0;
  endtask

  task automatic wait_done(input int g, input int le, input bit exp_bad, input string name);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (rdy[g] !== 1'b1 && lat < 1400 + 6 * le);
    checks++;
    if (rdy[g] !== 1'b1 || lat - 1 > 1284 + 6 * le) begin
      errors++;
      $display("[TB] FAIL %s_latency inst=%0d actual=%0d required<=%0d", name, g, lat - 1, 1284 + 6 * le);
    end
    check_output({name, "_bad"}, 32'(bad[g]), 32'(exp_bad));
  endtask

  task automatic load_ct(input int g, input logic [7:0] b [$]);
    foreach (b[n]) ct_mem[g][n] = b[n];
  endtask

  task automatic push_text(input int g, input int len, input string txt);
    push_exp(g, 0, len);
    for (int n = 0; n < txt.len(); n++) push_exp(g, n + 1, int'(txt[n]));
  endtask

  task automatic run_random(input int g, input int kb, input int maxl, input int L);
    logic [31:0] kv;
    bit          eb;
    int          le;
    kv = $urandom;
    if (kb == 3) kv[31:24] = 8'h00;
    ct_mem[g][0] = 8'(L);
    for (int n = 1; n < 256; n++) ct_mem[g][n] = 8'($urandom);
    ref_push(g, kv, kb, maxl, eb, le);
    apply_stimulus(g, kv);
    wait_done(g, le, eb, "random");
  endtask

  initial begin
    logic [7:0] ctv [$];
    bit         eb_eb;
    en[0] = 1'b0; en[1] = 1'b0;
    key_in[0] = '0; key_in[1] = '0;
    for (int g = 0; g < 2; g++)
      for (int n = 0; n < 256; n++) ct_mem[g][n] = 8'h00;

    repeat (3) @(negedge clk);
    check_output("reset_rdy", 32'(rdy[0]), 1);
    check_output("reset_s_wren", 32'(s_wren[0]), 0);
    check_output("reset_pt_wren", 32'(pt_wren[1]), 0);
    check_output("reset_s_addr", 32'(s_addr[0]), 0);
    check_output("reset_bad", 32'(bad[0]), 0);
    rst_n = 1'b1;

    // Zero key, zero length: identity S-box after INIT, only pt[0]=0 written
    ct_mem[0][0] = 8'h00;
    push_exp(0, 0, 0);
    apply_stimulus(0, 32'h0);
    fork
      begin
        repeat (256) @(posedge clk);
        #1 check_output("init_identity", 32'(sbox_identity(0)), 1);
      end
    join_none
    wait_done(0, 0, 1'b0, "zero_len");

    // "Key" / "Plaintext"
    ctv = {8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    load_ct(0, ctv);
    push_text(0, 9, "Plaintext");
    apply_stimulus(0, 32'h004B6579);
    wait_done(0, 9, 1'b0, "key_vec");

    // "Wiki" / "pedia" on the 4-byte-key instance
    ctv = {8'h05, 8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
    load_ct(1, ctv);
    push_text(1, 5, "pedia");
    apply_stimulus(1, 32'h57696B69);
    wait_done(1, 5, 1'b0, "wiki_vec");

    // Reset in the middle of KSA, then a fresh run must still decrypt
    ctv = {8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    load_ct(0, ctv);
    apply_stimulus(0, 32'h004B6579);
    repeat (700) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_output("midksa_rdy", 32'(rdy[0]), 1);
    check_output("midksa_s_wren", 32'(s_wren[0]), 0);
    check_output("midksa_s_addr", 32'(s_addr[0]), 0);
    check_output("midksa_pt_wren", 32'(pt_wren[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_output("midksa_no_resume", 32'(rdy[0]), 1);
    push_text(0, 9, "Plaintext");
    apply_stimulus(0, 32'h004B6579);
    wait_done(0, 9, 1'b0, "key_after_reset");

    // Single non-printable byte; a second en while busy must be ignored
    ctv = {8'h01, 8'h00};
    load_ct(0, ctv);
    push_exp(0, 0, 1);
    push_exp(0, 1, 8'hEB);
`ifdef ARC4_VALID_CHECK_EN
    eb_eb = 1'b1;
`else
    eb_eb = 1'b0;
`endif
    apply_stimulus(0, 32'h004B6579);
    repeat (10) @(negedge clk);
    key_in[0] = 32'h00123456;
    en[0]     = 1'b1;
    repeat (3) @(negedge clk);
    en[0]     = 1'b0;
    wait_done(0, 1, eb_eb, "eb_vec");
    repeat (4) @(negedge clk);
    check_output("busy_en_ignored", 32'(rdy[0]), 1);

    // Randomized runs, including maximum and truncated lengths
    for (int r = 0; r < 4; r++) run_random(0, 3, 255, $urandom_range(0, 24));
    run_random(0, 3, 255, 255);
    for (int r = 0; r < 3; r++) run_random(1, 4, MAXL1, $urandom_range(10, 40));
    run_random(1, 4, MAXL1, 200);

    repeat (5) @(negedge clk);
    check_output("queue0_drained", 32'(exp_q0.size()), 0);
    check_output("queue1_drained", 32'(exp_q1.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
